mem_burst_bridge: RTL and testbench
===================================

Name: mem_burst_bridge

Overview:
- Downstream of the CPU bus master: converts its Avalon-MM burst requests (32-bit words, bursts of 1..8) into commands and data on a Spartan-6 MCB user port.
- Stages write data into the MCB write FIFO before issuing the write command.
- Issues read commands, then drains the MCB read FIFO back as Avalon read beats.
- Holds off all traffic until DRAM calibration completes.

Parameters:
- ADDR_W, 28: Avalon word-address width; the MCB byte address is ADDR_W+2 bits.
- BURST_W, 4: Avalon burstcount width.
- MAX_BURST, 8: largest legal burst in words; must be ≤ 64 (MCB bl limit).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- calib_done  in  1  MCB calibration complete
- avm_address  in  ADDR_W  word address of first beat
- avm_burstcount  in  BURST_W  beats in burst
- avm_read  in  1  read request
- avm_write  in  1  write request / write beat
- avm_writedata  in  32  write data
- avm_byteenable  in  4  byte enables
- avm_waitrequest  out  1  stall; request or beat accepted when low
- avm_readdata  out  32  read data
- avm_readdatavalid  out  1  read beat valid
- cmd_en  out  1  MCB command strobe
- cmd_instr  out  3  000 write, 001 read
- cmd_bl  out  6  burst length minus 1
- cmd_byte_addr  out  ADDR_W+2  {avm_address,2'b00} of the latched request
- cmd_full  in  1  MCB command FIFO full
- wr_en  out  1  write FIFO push
- wr_data  out  32  write FIFO data
- wr_mask  out  4  ~byteenable
- wr_full  in  1  write FIFO full
- rd_en  out  1  read FIFO pop
- rd_data  in  32  read FIFO head, valid while rd_empty is low
- rd_empty  in  1  read FIFO empty

Behaviour:
- Reset (async, rst=1): state=IDLE; avm_waitrequest=1; all other outputs 0; latched address, length and beat counter cleared.
- Latched length: burstcount==0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
- Request priority: a read and write together in IDLE is illegal; the block services the read and pushes no write data.
- Address wrap: no boundary check; the address is passed through and wraps naturally at the top of the ADDR_W space.
- IDLE:
  - avm_waitrequest=1 while calib_done=0.
  - avm_read: waitrequest=0 for one cycle; latch address and length; go to RDCMD.
  - avm_write: waitrequest=wr_full. On acceptance, push beat 0 (wr_en=1, wr_data=writedata, wr_mask=~byteenable) and latch address and length. Go to WRCMD if length=1, else WRDATA.
- WRDATA:
  - waitrequest=wr_full.
  - Each cycle with avm_write=1 and waitrequest=0, push one beat and increment the counter.
  - After the last beat is pushed, go to WRCMD.
  - avm_write=0 mid-burst is an idle cycle: no push.
- WRCMD:
  - waitrequest=1.
  - Assert cmd_en=1 with instr=000 and bl=length-1 in the first cycle cmd_full=0; then go to IDLE.
  - cmd_en is a single-cycle pulse.
- RDCMD:
  - waitrequest=1.
  - Issue cmd_en (instr=001, bl=length-1) when cmd_full=0; then go to RDDATA.
- RDDATA:
  - waitrequest=1.
  - rd_en=!rd_empty while beats remain.
  - On each pop: avm_readdata<=rd_data and avm_readdatavalid<=1, registered, so they appear one cycle after rd_en. Otherwise readdatavalid=0.
  - The cycle the last beat is popped, go to IDLE. The final readdatavalid may coincide with a new request being accepted in IDLE; this is allowed.
- Signal rules:
  - wr_en never asserts when wr_full=1.
  - rd_en never asserts when rd_empty=1.
  - cmd_en never asserts when cmd_full=1.
- Latency: single-beat write is accepted at T, command issued at T+1. Single-beat read is accepted at T, command at T+1, pop at the first non-empty cycle ≥T+2, data one cycle after the pop.
- calib_done deasserting mid-transaction has no effect until the block returns to IDLE.
- Reset mid-transaction aborts immediately. MCB FIFO contents are not the block's concern.

Test Plan:
- Reset with calib_done=0, then issue a read → waitrequest stays 1 and no cmd_en until calib_done=1; all outputs 0 during reset.
- Write burst of 4 at address 0x100 (data 0xA0..0xA3, be=4'b1111), wr_full=0 → four wr_en pulses with wr_mask=0, then one cmd_en with instr=000, bl=3, byte_addr=0x400.
- Same burst with wr_full=1 for 3 cycles after beat 1 → waitrequest=1 during those cycles; exactly 4 pushes; data order preserved.
- Read burst of 8 at 0x2000, MCB returns 0x11..0x18 with rd_empty toggling → cmd bl=7, byte_addr=0x8000; eight readdatavalid beats in order, each one cycle after its rd_en.
- burstcount=0 write with be=4'b0101 and cmd_full=1 for 5 cycles → one push with wr_mask=4'b1010, cmd_en delayed until cmd_full=0, bl=0.
- Assert rst during RDDATA after 3 of 8 beats → outputs return to reset values asynchronously; after release, a fresh single read completes normally.

Source files
------------

// File: rtl/mem_burst_bridge.sv
// Avalon-MM burst master to Spartan-6 MCB user-port bridge.
// Ports: clk/rst, calib_done, Avalon slave (avm_*), MCB cmd/wr/rd FIFO ports.
module mem_burst_bridge #(
  parameter int ADDR_W    = 28,
  parameter int BURST_W   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calib_done,
  input  logic [ADDR_W-1:0] avm_address,
  input  logic [BURST_W-1:0] avm_burstcount,
  input  logic              avm_read,
  input  logic              avm_write,
  input  logic [31:0]       avm_writedata,
  input  logic [3:0]        avm_byteenable,
  output logic              avm_waitrequest,
  output logic [31:0]       avm_readdata,
  output logic              avm_readdatavalid,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W+1:0] cmd_byte_addr,
  input  logic              cmd_full,
  output logic              wr_en,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_mask,
  input  logic              wr_full,
  output logic              rd_en,
  input  logic [31:0]       rd_data,
  input  logic              rd_empty
);

  // Wide enough to hold a 64-beat length
  localparam int LEN_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    WRDATA,
    WRCMD,
    RDCMD,
    RDDATA
  } state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_in;
  logic [31:0]        rdata_q;
  logic               rdv_q;
  logic               load;
  logic               cnt_inc;
  logic               last;

  // Zero-length bursts become single beats; oversize ones are clamped
  always_comb begin
    len_in = LEN_W'(avm_burstcount);
    if (avm_burstcount == '0)
      len_in = LEN_W'(1);
    else if (32'(avm_burstcount) > MAX_BURST)
      len_in = LEN_W'(MAX_BURST);
  end

  assign last          = (cnt_q + LEN_W'(1)) == len_q;
  assign cmd_byte_addr = {addr_q, 2'b00};
  assign avm_readdata  = rdata_q;
  assign avm_readdatavalid = rdv_q;

  always_comb begin
    state_nx        = state;
    avm_waitrequest = 1'b1;
    cmd_en          = 1'b0;
    cmd_instr       = 3'b000;
    cmd_bl          = 6'd0;
    wr_en           = 1'b0;
    wr_data         = 32'd0;
    wr_mask         = 4'd0;
    rd_en           = 1'b0;
    load            = 1'b0;
    cnt_inc         = 1'b0;
    // Outputs stay quiet while reset is held, whatever the host drives
    if (!rst) begin
      case (state)
        IDLE: begin
          if (calib_done) begin
            // Read wins if both are raised together
            if (avm_read) begin
              avm_waitrequest = 1'b0;
              load            = 1'b1;
              state_nx        = RDCMD;
            end else if (avm_write) begin
              avm_waitrequest = wr_full;
              if (!wr_full) begin
                wr_en    = 1'b1;
                wr_data  = avm_writedata;
                wr_mask  = ~avm_byteenable;
                load     = 1'b1;
                cnt_inc  = 1'b1;
                state_nx = (len_in == LEN_W'(1)) ? WRCMD : WRDATA;
              end
            end
          end
        end
        WRDATA: begin
          avm_waitrequest = wr_full;
          if (avm_write && !wr_full) begin
            wr_en   = 1'b1;
            wr_data = avm_writedata;
            wr_mask = ~avm_byteenable;
            cnt_inc = 1'b1;
            if (last)
              state_nx = WRCMD;
          end
        end
        WRCMD: begin
          if (!cmd_full) begin
            cmd_en    = 1'b1;
            cmd_instr = 3'b000;
            cmd_bl    = 6'(len_q - LEN_W'(1));
            state_nx  = IDLE;
          end
        end
        RDCMD: begin
          if (!cmd_full) begin
            cmd_en    = 1'b1;
            cmd_instr = 3'b001;
            cmd_bl    = 6'(len_q - LEN_W'(1));
            state_nx  = RDDATA;
          end
        end
        RDDATA: begin
          if (!rd_empty) begin
            rd_en   = 1'b1;
            cnt_inc = 1'b1;
            if (last)
              state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        addr_q <= avm_address;
        len_q  <= len_in;
        // A write accepts beat 0 in the same cycle it latches
        cnt_q  <= cnt_inc ? LEN_W'(1) : '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      rdv_q <= rd_en;
      if (rd_en)
        rdata_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_burst_bridge.sv
// Scoreboard testbench for mem_burst_bridge.
// Drives Avalon host traffic and a small MCB FIFO model; a monitor checks outputs.
module tb_mem_burst_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calib_done = 1'b0;
  logic [27:0] avm_address = '0;
  logic [3:0]  avm_burstcount = '0;
  logic        avm_read = 1'b0;
  logic        avm_write = 1'b0;
  logic [31:0] avm_writedata = '0;
  logic [3:0]  avm_byteenable = '0;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full = 1'b0;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full = 1'b0;
  logic        rd_en;
  logic [31:0] rd_data = '0;
  logic        rd_empty = 1'b1;

  mem_burst_bridge #(
    .ADDR_W(28), .BURST_W(4), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
  } cmd_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  m;
  } wbeat_t;

  cmd_t        cq[$];
  wbeat_t      wq[$];
  logic [31:0] rq[$];
  logic [31:0] mq[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   rdv_cnt = 0;
  logic prev_rden = 1'b0;
  logic rd_gate = 1'b0;
  logic toggle_en = 1'b0;
  logic do_pop;
  cmd_t        ce;
  wbeat_t      we;
  logic [31:0] re;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: output event seen, none expected", name);
  endfunction

  function automatic void upd();
    rd_empty = rd_gate || (mq.size() == 0);
    rd_data  = (mq.size() != 0) ? mq[0] : 32'h0;
  endfunction

  // MCB read FIFO model: pop after the edge so the DUT samples the old head
  always @(posedge clk) begin
    do_pop = rd_en && !rd_empty;
    #1;
    if (do_pop && mq.size() != 0)
      void'(mq.pop_front());
    if (toggle_en)
      rd_gate = ~rd_gate;
    upd();
  end

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_rden = 1'b0;
    end else begin
      if (wr_en) begin
        chk("wr_en_while_full", 64'(wr_full), 64'(0));
        if (wq.size() == 0) unexpected("wr_beat");
        else begin
          we = wq.pop_front();
          chk("wr_beat", 64'({wr_data, wr_mask}), 64'(we));
        end
      end
      if (cmd_en) begin
        chk("cmd_en_while_full", 64'(cmd_full), 64'(0));
        if (cq.size() == 0) unexpected("cmd");
        else begin
          ce = cq.pop_front();
          chk("cmd", 64'({cmd_instr, cmd_bl, cmd_byte_addr}), 64'(ce));
        end
      end
      if (rd_en)
        chk("rd_en_while_empty", 64'(rd_empty), 64'(0));
      if (avm_readdatavalid) begin
        rdv_cnt++;
        chk("rdv_after_rd_en", 64'(prev_rden), 64'(1));
        if (rq.size() == 0) unexpected("rd_beat");
        else begin
          re = rq.pop_front();
          chk("rd_beat", 64'(avm_readdata), 64'(re));
        end
      end
      prev_rden = rd_en;
    end
  end

  task automatic chk_reset_outputs();
    chk("reset_ctrl",
        64'({avm_waitrequest, avm_readdatavalid, cmd_en, cmd_instr,
             cmd_bl, wr_en, wr_mask, rd_en}),
        64'(18'h20000));
    chk("reset_data", 64'({avm_readdata, wr_data}), 64'(0));
    chk("reset_addr", 64'(cmd_byte_addr), 64'(0));
  endtask

  task automatic accept_wait(string name);
    int  t = 0;
    logic acc = 1'b0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = !avm_waitrequest;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) unexpected({name, "_accept_timeout"});
  endtask

  task automatic drain();
    int t = 0;
    while ((cq.size() != 0 || wq.size() != 0 || rq.size() != 0) && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 300) unexpected("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [27:0] a, input logic [3:0] bc,
                          input int n, input logic [31:0] d0,
                          input logic [3:0] be, input int stall_at,
                          input logic [5:0] bl);
    cq.push_back('{3'b000, bl, {a, 2'b00}});
    for (int i = 0; i < n; i++) begin
      wq.push_back('{d0 + 32'(i), ~be});
      avm_address    = a;
      avm_burstcount = bc;
      avm_writedata  = d0 + 32'(i);
      avm_byteenable = be;
      avm_write      = 1'b1;
      if (i == stall_at) begin
        wr_full = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("wait_on_wr_full", 64'(avm_waitrequest), 64'(1));
          @(posedge clk);
          #1;
        end
        wr_full = 1'b0;
      end
      accept_wait("write");
    end
    avm_write = 1'b0;
  endtask

  task automatic do_read(input logic [27:0] a, input logic [3:0] bc,
                         input int n, input logic [31:0] d0,
                         input logic [5:0] bl);
    cq.push_back('{3'b001, bl, {a, 2'b00}});
    for (int i = 0; i < n; i++) begin
      mq.push_back(d0 + 32'(i));
      rq.push_back(d0 + 32'(i));
    end
    upd();
    avm_address    = a;
    avm_burstcount = bc;
    avm_read       = 1'b1;
    accept_wait("read");
    avm_read = 1'b0;
  endtask

  initial begin
    int t;
    int base;
    upd();
    #12;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Held off until calibration completes
    avm_address    = 28'h10;
    avm_burstcount = 4'd1;
    avm_read       = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("precal_hold", 64'({avm_waitrequest, cmd_en}), 64'(2'b10));
      @(posedge clk);
      #1;
    end
    avm_read = 1'b0;
    calib_done = 1'b1;
    do_read(28'h10, 4'd1, 1, 32'hDEAD, 6'd0);
    drain();

    // Write burst of 4
    do_write(28'h100, 4'd4, 4, 32'hA0, 4'b1111, -1, 6'd3);
    drain();

    // Same burst, write FIFO full for 3 cycles mid-burst
    do_write(28'h100, 4'd4, 4, 32'hA0, 4'b1111, 2, 6'd3);
    drain();

    // Read burst of 8 with rd_empty toggling
    toggle_en = 1'b1;
    do_read(28'h2000, 4'd8, 8, 32'h11, 6'd7);
    drain();
    toggle_en = 1'b0;
    rd_gate = 1'b0;
    upd();

    // Zero burstcount with the command FIFO full
    cmd_full = 1'b1;
    do_write(28'h55, 4'd0, 1, 32'h12345678, 4'b0101, -1, 6'd0);
    repeat (5) begin
      @(negedge clk);
      chk("cmd_hold_on_full", 64'(cmd_en), 64'(0));
      @(posedge clk);
      #1;
    end
    cmd_full = 1'b0;
    drain();

    // Oversize burst clamps to 8, address at the top of the space
    do_write(28'hFFFFFFF, 4'hF, 8, 32'hC0, 4'b0011, -1, 6'd7);
    drain();

    // Reset in the middle of a read burst
    base = rdv_cnt;
    do_read(28'h800, 4'd8, 8, 32'h100, 6'd7);
    t = 0;
    while (rdv_cnt < base + 3 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) unexpected("midreset_wait_timeout");
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    rq.delete();
    mq.delete();
    cq.delete();
    wq.delete();
    upd();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_read(28'h44, 4'd1, 1, 32'h5A5A0000, 6'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
